// File: rtl/apb_master_arbiter_if.sv
// APB master-side bus bundle for apb_master_arbiter.
// Handshake: once psel rises the transfer is committed; the slave side
// completes the ACCESS phase by raising pready in a cycle where psel and
// penable are both high, with prdata/pslverr valid in that same cycle.
// decode_error is valid whenever psel is high and refers to the current paddr.
interface apb_master_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;
  logic                  decode_error;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr, decode_error
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr, decode_error
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters.
// Sequences IDLE -> SETUP -> ACCESS -> DONE; unmapped addresses (decode_error
// in SETUP) skip ACCESS and complete with an error.
// Optional feature macro: APB_TIMEOUT_EN -- bounds the ACCESS wait to
// TIMEOUT_CYCLES pready-low cycles and then completes with an error.
// Requester handshake: req[i] is held high (with stable addr/write/wdata)
// until done[i] pulses for one cycle; the requester drops req the cycle after.
module apb_master_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [1:0]                    dbg_state,
  apb_master_arbiter_if.master          apb
);

  localparam int GW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("apb_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [GW-1:0]         grant;
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         pick;
  logic                  pick_valid;
  logic [GW-1:0]         rr_idx;
  logic                  timeout_hit;
  logic                  err_now;
  logic                  psel_d;
  logic                  penable_d;
  logic [NUM_REQ-1:0]    done_d;
  logic                  rsp_err_d;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign dbg_state = state;

  // Round-robin pick: scan from last_grant+1 with wrap, first requester wins.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    rr_idx     = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = (rr_idx == GW'(NUM_REQ - 1)) ? '0 : rr_idx + 1'b1;
      if (!pick_valid && req[rr_idx]) begin
        pick       = rr_idx;
        pick_valid = 1'b1;
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  // Count pready-low ACCESS cycles; the count restarts on every ACCESS entry.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt <= '0;
    end else if (state != S_ACCESS) begin
      wait_cnt <= '0;
    end else if (!apb.pready) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // Fires in the last allowed pready-low ACCESS cycle.
  assign timeout_hit = !apb.pready && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (pick_valid) next_state = S_SETUP;
      S_SETUP:  next_state = apb.decode_error ? S_DONE : S_ACCESS;
      S_ACCESS: if (apb.pready || timeout_hit) next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Output decode for the coming cycle; the values are registered below so no
  // combinational path exists from slave inputs to outputs.
  always_comb begin
    // DONE is entered from SETUP only on a decode error, and from ACCESS
    // either with pready (slave error status) or on timeout (forced error).
    err_now   = (state == S_SETUP) ? 1'b1 : (apb.pready ? apb.pslverr : 1'b1);
    psel_d    = (next_state == S_SETUP) || (next_state == S_ACCESS);
    penable_d = (next_state == S_ACCESS);
    done_d    = '0;
    rsp_err_d = 1'b0;
    if (next_state == S_DONE) begin
      done_d[grant] = 1'b1;
      rsp_err_d     = err_now;
    end
  end

  // Registered control outputs.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
      done        <= '0;
      rsp_err     <= 1'b0;
    end else begin
      apb.psel    <= psel_d;
      apb.penable <= penable_d;
      done        <= done_d;
      rsp_err     <= rsp_err_d;
    end
  end

  // Grant bookkeeping, transfer payload capture and read-data return.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      grant      <= GW'(NUM_REQ - 1);
      last_grant <= GW'(NUM_REQ - 1);
      apb.paddr  <= '0;
      apb.pwrite <= 1'b0;
      apb.pwdata <= '0;
      rsp_rdata  <= '0;
    end else begin
      if (state == S_IDLE && pick_valid) begin
        grant      <= pick;
        apb.paddr  <= addr_arr[pick];
        apb.pwrite <= req_write[pick];
        apb.pwdata <= wdata_arr[pick];
      end
      if (state == S_ACCESS && apb.pready && !apb.pwrite) begin
        rsp_rdata <= apb.prdata;
      end
      if (state == S_DONE) begin
        last_grant <= grant;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Testbench for apb_master_arbiter: requester driver, APB slave model with a
// round-robin reference, scoreboard monitor on done, summary report.
module tb_apb_master_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 3;
  localparam int TO = 16;
  localparam int W  = N + 1 + DW;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic presetn;
  always #5 pclk = ~pclk;

  logic [N-1:0]    req;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    done;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [1:0]      dbg_state;

  apb_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

  apb_master_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dbg_state(dbg_state),
    .apb(apb)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [N-1:0] done_log[$];
  int done_cnt = 0;
  logic [DW-1:0] last_rdata;
  logic          last_err;
  logic [N-1:0]  last_done;
  int            last_acc_n;
  logic          last_saw_pen;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus controls ----------------
  int            pend_seq [N];
  int            taken_seq[N];
  logic          pend_write[N];
  logic [AW-1:0] pend_addr [N];
  logic [DW-1:0] pend_data [N];
  logic          rnd_en = 1'b0;
  logic          dir_en = 1'b1;
  logic          dir_dec = 1'b0;
  int            dir_waits = 0;
  logic          dir_err = 1'b0;
  logic [DW-1:0] dir_rdata = '0;

  task automatic issue(int i, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
    pend_write[i] = w;
    pend_addr[i]  = a;
    pend_data[i]  = d;
    pend_seq[i]   = pend_seq[i] + 1;
  endtask

  // ---------------- requester driver ----------------
  initial begin
    logic [N-1:0] seen;
    req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      pend_seq[i] = 0; taken_seq[i] = 0;
    end
    forever begin
      @(negedge pclk);
      seen = done;
      @(posedge pclk);
      #1;
      if (!presetn) begin
        req = '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (req[i]) begin
            if (seen[i]) req[i] = 1'b0;
          end else if (pend_seq[i] != taken_seq[i]) begin
            taken_seq[i] = taken_seq[i] + 1;
            req_write[i] = pend_write[i];
            req_addr[i*AW +: AW]  = pend_addr[i];
            req_wdata[i*DW +: DW] = pend_data[i];
            req[i] = 1'b1;
          end else if (rnd_en && $urandom_range(0, 3) == 0) begin
            req_write[i] = 1'($urandom_range(0, 1));
            req_addr[i*AW +: AW]  = $urandom;
            req_wdata[i*DW +: DW] = $urandom;
            req[i] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- APB slave + reference model ----------------
  // Reference: grant = first pending requester after the previous grant in
  // circular order; response error/data follow what this slave returned.
  function automatic int predict(logic [N-1:0] r, int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  localparam int PH_NONE = 0, PH_SETUP = 1, PH_ACCESS = 2, PH_DONE = 3;

  initial begin
    int            model_last;
    logic [DW-1:0] model_rdata;
    int            phase_exp;
    logic [N-1:0]  req_prev;
    int            cur_id;
    logic          cur_write;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;
    logic          s_dec, s_err;
    int            s_waits, acc_n;
    logic [DW-1:0] s_rd;
    logic [N-1:0]  oh;
    model_last = N - 1; model_rdata = '0; phase_exp = PH_NONE; req_prev = '0;
    cur_id = 0; cur_write = 0; cur_addr = '0; cur_wdata = '0;
    s_dec = 0; s_err = 0; s_waits = 0; acc_n = 0; s_rd = '0;
    apb.pready = 1'b0; apb.prdata = '0; apb.pslverr = 1'b0; apb.decode_error = 1'b0;
    forever begin
      @(negedge pclk);
      if (!presetn) begin
        model_last = N - 1; model_rdata = '0; phase_exp = PH_NONE; req_prev = '0;
        apb.pready = 1'b0; apb.decode_error = 1'b0;
        continue;
      end
      case (phase_exp)
        PH_SETUP:  check("setup_timing", {apb.psel, apb.penable}, 2'b10);
        PH_ACCESS: check("access_timing", {apb.psel, apb.penable}, 2'b11);
        PH_DONE:   check("done_timing", {apb.psel, apb.penable, |done}, 3'b001);
        default: ;
      endcase
      phase_exp = PH_NONE;
      apb.decode_error = 1'b0;
      apb.pready = 1'b0;
      apb.prdata = $urandom;
      apb.pslverr = 1'($urandom_range(0, 1));
      if (apb.psel && !apb.penable) begin
        cur_id = predict(req_prev, model_last);
        check("grant_exists", (cur_id >= 0), 1);
        if (cur_id < 0) cur_id = 0;
        cur_write = req_write[cur_id];
        cur_addr  = req_addr[cur_id*AW +: AW];
        cur_wdata = req_wdata[cur_id*DW +: DW];
        check("setup_paddr", apb.paddr, cur_addr);
        check("setup_pwrite", apb.pwrite, cur_write);
        check("setup_pwdata", apb.pwdata, cur_wdata);
        model_last = cur_id;
        if (dir_en) begin
          s_dec = dir_dec; s_waits = dir_waits; s_err = dir_err; s_rd = dir_rdata;
        end else begin
          s_dec = ($urandom_range(0, 7) == 0); s_waits = $urandom_range(0, 3);
          s_err = ($urandom_range(0, 3) == 0); s_rd = $urandom;
        end
        acc_n = 0;
        last_saw_pen = 1'b0;
        apb.decode_error = s_dec;
        if (s_dec) begin
          oh = '0; oh[cur_id] = 1'b1;
          exp_q.push_back({oh, 1'b1, model_rdata});
          last_acc_n = 0;
          phase_exp = PH_DONE;
        end else begin
          phase_exp = PH_ACCESS;
        end
      end else if (apb.psel && apb.penable) begin
        acc_n++;
        last_saw_pen = 1'b1;
        check("access_paddr_stable", apb.paddr, cur_addr);
        check("access_pwrite_stable", apb.pwrite, cur_write);
        check("access_pwdata_stable", apb.pwdata, cur_wdata);
        if (acc_n > s_waits) begin
          apb.pready = 1'b1; apb.prdata = s_rd; apb.pslverr = s_err;
          if (!cur_write) model_rdata = s_rd;
          oh = '0; oh[cur_id] = 1'b1;
          exp_q.push_back({oh, s_err, model_rdata});
          last_acc_n = acc_n;
          phase_exp = PH_DONE;
        end else begin
          phase_exp = PH_ACCESS;
`ifdef APB_TIMEOUT_EN
          if (acc_n == TO) begin
            oh = '0; oh[cur_id] = 1'b1;
            exp_q.push_back({oh, 1'b1, model_rdata});
            last_acc_n = acc_n;
            phase_exp = PH_DONE;
          end
`endif
        end
      end else if (done == '0 && req != '0) begin
        phase_exp = PH_SETUP;
      end
      req_prev = req;
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge pclk);
      if (presetn && done != '0) begin
        check("done_onehot", $onehot(done), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", done, e[W-1 -: N]);
          check("rsp_err", rsp_err, e[DW]);
          check("rsp_rdata", rsp_rdata, e[DW-1:0]);
        end
        last_done = done; last_err = rsp_err; last_rdata = rsp_rdata;
        done_log.push_back(done);
        done_cnt++;
      end
    end
  end

  // ---------------- sequence ----------------
  task automatic wait_done(int target, int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge pclk);
      n++;
    end
    check("wait_done_budget", (done_cnt >= target), 1);
    repeat (2) @(negedge pclk);
  endtask

  initial begin
    int base, n;
    presetn = 1'b0;
    repeat (3) @(negedge pclk);
    check("rst_psel", apb.psel, 0);
    check("rst_penable", apb.penable, 0);
    check("rst_pwrite", apb.pwrite, 0);
    check("rst_done", done, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_paddr", apb.paddr, 0);
    check("rst_pwdata", apb.pwdata, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    presetn = 1'b1;
    repeat (2) @(negedge pclk);

    // Single zero-wait write from requester 0.
    dir_en = 1; dir_dec = 0; dir_waits = 0; dir_err = 0; dir_rdata = '0;
    issue(0, 1'b1, 32'h0001_0004, 32'hA5A5_5A5A);
    wait_done(done_cnt + 1, 50);
    check("t1_done_id", last_done, 3'b001);
    check("t1_err", last_err, 0);
    check("t1_access_len", last_acc_n, 1);

    // Read with three wait states.
    dir_waits = 3; dir_rdata = 32'hDEAD_BEEF;
    issue(1, 1'b0, 32'h0001_0100, 32'h0);
    wait_done(done_cnt + 1, 50);
    check("t2_access_len", last_acc_n, 4);
    check("t2_rdata", last_rdata, 32'hDEAD_BEEF);

    // Unmapped address: no ACCESS phase, error completion.
    dir_waits = 0; dir_dec = 1;
    issue(0, 1'b0, 32'h0003_0000, 32'h0);
    wait_done(done_cnt + 1, 50);
    check("t3_no_penable", last_saw_pen, 0);
    check("t3_err", last_err, 1);
    check("t3_rdata_kept", last_rdata, 32'hDEAD_BEEF);

    // Slave error followed by a clean transfer.
    dir_dec = 0; dir_err = 1;
    issue(2, 1'b1, 32'h0000_0040, 32'h1234_5678);
    wait_done(done_cnt + 1, 50);
    check("t4_err", last_err, 1);
    dir_err = 0; dir_rdata = 32'h0BAD_F00D;
    issue(1, 1'b0, 32'h0000_0080, 32'h0);
    wait_done(done_cnt + 1, 50);
    check("t4_err_clear", last_err, 0);
    check("t4_rdata", last_rdata, 32'h0BAD_F00D);

    // Reset in the middle of ACCESS aborts without a completion.
    dir_waits = 1000;
    issue(0, 1'b0, 32'h0002_0010, 32'h0);
    n = 0;
    while (!(apb.psel && apb.penable) && n < 50) begin
      @(negedge pclk);
      n++;
    end
    check("abort_reached_access", apb.penable, 1);
    base = done_cnt;
    presetn = 1'b0;
    #1;
    check("abort_psel", apb.psel, 0);
    check("abort_penable", apb.penable, 0);
    check("abort_done", done, 0);
    check("abort_rsp_err", rsp_err, 0);
    check("abort_paddr", apb.paddr, 0);
    check("abort_rsp_rdata", rsp_rdata, 0);
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    dir_waits = 0;
    repeat (10) @(negedge pclk);
    check("abort_no_done", done_cnt, base);
    check("abort_queue_empty", exp_q.size(), 0);

    // Two requesters kept busy: grants alternate starting at 0.
    base = done_log.size();
    issue(0, 1'b1, 32'h0000_1000, 32'h0000_0A0A);
    issue(1, 1'b1, 32'h0000_2000, 32'h0000_0B0B);
    #1;
    issue(0, 1'b1, 32'h0000_1000, 32'h0000_0A0A);
    issue(1, 1'b1, 32'h0000_2000, 32'h0000_0B0B);
    wait_done(done_cnt + 4, 100);
    if (done_log.size() >= base + 4) begin
      check("alt_0", done_log[base],     3'b001);
      check("alt_1", done_log[base + 1], 3'b010);
      check("alt_2", done_log[base + 2], 3'b001);
      check("alt_3", done_log[base + 3], 3'b010);
    end else begin
      check("alt_count", done_log.size() - base, 4);
    end

`ifdef APB_TIMEOUT_EN
    // pready stuck low: completes with error after TO ACCESS cycles.
    dir_waits = 1000;
    issue(2, 1'b0, 32'h0000_3000, 32'h0);
    wait_done(done_cnt + 1, 60);
    check("to_err", last_err, 1);
    check("to_access_len", last_acc_n, TO);
    dir_waits = 0;
`endif

    // Randomized traffic from all requesters.
    dir_en = 0; rnd_en = 1;
    repeat (3000) @(negedge pclk);
    rnd_en = 0;
    n = 0;
    while ((req != '0 || exp_q.size() != 0) && n < 200) begin
      @(negedge pclk);
      n++;
    end
    repeat (3) @(negedge pclk);
    check("drain_req_idle", req, 0);
    check("drain_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Shares one APB master port between `NUM_REQ` internal requesters and sequences the APB SETUP/ACCESS phases.
- Drives `paddr`/`psel` into the APB address decoder; `psel` feeds the decoder's master select input.
- Consumes the decoder's `decode_error` to terminate unmapped accesses without touching any slave.
- Returns read data and error status to the granted requester.

## Interface
- `ADDR_WIDTH`, 32, APB address width
- `DATA_WIDTH`, 32, APB data width
- `NUM_REQ`, 2, number of requesters (2..8)
- `TIMEOUT_CYCLES`, 16, ACCESS-phase wait limit (used only with `APB_TIMEOUT_EN`)

Ports:
- `pclk`  in  1  clock
- `presetn`  in  1  asynchronous active-low reset (one clock, async active-low reset)
- `req`  in  NUM_REQ  per-requester transfer request, held high until its `done`
- `req_write`  in  NUM_REQ  per-requester direction, 1 = write
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i uses slice i
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  flattened write data; requester i uses slice i
- `done`  out  NUM_REQ  one-hot, one-cycle completion pulse
- `rsp_rdata`  out  DATA_WIDTH  read data, valid with `done`
- `rsp_err`  out  1  error flag, valid with `done`
- `paddr`  out  ADDR_WIDTH  APB address
- `psel`  out  1  APB select, to the decoder
- `penable`  out  1  APB enable
- `pwrite`  out  1  APB direction
- `pwdata`  out  DATA_WIDTH  APB write data
- `prdata`  in  DATA_WIDTH  read data from the muxed slave
- `pready`  in  1  slave ready
- `pslverr`  in  1  slave error
- `decode_error`  in  1  decoder error for the current `paddr`

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- **IDLE**
  - If any `req` is high, grant via round-robin.
  - Search starts at (last_grant+1) mod NUM_REQ; lowest index wins within the rotated order.
  - last_grant resets to NUM_REQ-1, so requester 0 has first priority after reset.
  - Register the winner's addr, write and wdata into `paddr`/`pwrite`/`pwdata`, then go to SETUP.
- **SETUP**
  - `psel`=1, `penable`=0.
  - If `decode_error`=1, go to DONE with err=1; ACCESS and `penable` never occur.
  - Otherwise go to ACCESS.
- **ACCESS**
  - `psel`=1, `penable`=1.
  - Stay while `pready`=0.
  - When `pready`=1, capture `prdata` (reads only; writes leave `rsp_rdata` unchanged) and capture `pslverr` as err, then go to DONE.
- **DONE**
  - `psel`=0, `penable`=0.
  - `done[grant]`=1, `rsp_err`=err; update last_grant; go to IDLE.
- Requesters must drop `req` the cycle after `done` is sampled.
- `paddr`, `pwrite` and `pwdata` hold stable from SETUP through the end of ACCESS.
- Requests arriving during a transfer wait; a request is never lost and never preempted.

## Timing
- Reset: state=IDLE, last_grant=NUM_REQ-1.
  - `psel`, `penable`, `pwrite`, `done`, `rsp_err` = 0.
  - `paddr`, `pwdata`, `rsp_rdata` = 0.
- Zero-wait transfer: req seen in IDLE (cycle 0), SETUP on cycle 1, ACCESS on cycle 2, `done` on cycle 3. Minimum 4 cycles per transfer.
- Each `pready`-low cycle adds one cycle.
- Decode-error transfer: IDLE, SETUP, DONE (3 cycles).
- All outputs are registered; no combinational path from `pready`/`prdata` to outputs.
- Reset asserted mid-transfer aborts immediately to reset values; no `done` is issued for the aborted transfer.

## Configuration
- `APB_TIMEOUT_EN` defined:
  - A counter clears on ACCESS entry and increments each ACCESS cycle with `pready`=0.
  - When it reaches TIMEOUT_CYCLES, go to DONE with err=1 and `rsp_rdata` unchanged.
  - `psel`/`penable` drop in DONE as normal.
- Undefined: no counter; ACCESS waits indefinitely for `pready`.

## Test plan
- Single write, req[0] addr 0x0001_0004 data 0xA5A5_5A5A, `pready`=1 -> `psel` cycle 1, `penable` cycle 2, `done`=01 cycle 3, `rsp_err`=0.
- Read with 3 wait states, `prdata`=0xDEAD_BEEF -> ACCESS lasts 4 cycles; `done` with `rsp_rdata`=0xDEAD_BEEF.
- req[0] and req[1] held continuously, 4 transfers -> grants alternate 0,1,0,1 from reset; each `done` is one-hot.
- Addr 0x0003_0000 with `decode_error`=1 in SETUP -> `penable` never asserts; `done` 2 cycles after grant with `rsp_err`=1.
- Slave returns `pslverr`=1 with `pready` -> `rsp_err`=1; the next transfer shows `rsp_err`=0.
- `APB_TIMEOUT_EN` with TIMEOUT_CYCLES=16 and `pready` stuck low -> `done` with `rsp_err`=1 after 16 ACCESS cycles. Also: `presetn` low mid-ACCESS -> all outputs return to 0 with no `done`.
